// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - shared SHA type codes, digest lengths and streamer state encoding
package sha_pkg;

  localparam logic [1:0] SHA256 = 2'b00;
  localparam logic [1:0] SHA384 = 2'b01;
  localparam logic [1:0] SHA512 = 2'b10;

  localparam logic [6:0] DLEN_SHA256 = 7'd32;
  localparam logic [6:0] DLEN_SHA384 = 7'd48;
  localparam logic [6:0] DLEN_SHA512 = 7'd64;

  localparam logic ST_IDLE_ENC = 1'b0;
  localparam logic ST_SEND_ENC = 1'b1;

  typedef enum logic {
    ST_IDLE = ST_IDLE_ENC,
    ST_SEND = ST_SEND_ENC
  } state_t;

  // Code 2'b11 is folded into SHA512.
  function automatic logic [6:0] digest_len(input logic [1:0] t);
    case (t)
      SHA256:  return DLEN_SHA256;
      SHA384:  return DLEN_SHA384;
      default: return DLEN_SHA512;
    endcase
  endfunction

endpackage

// File: rtl/digest_streamer.sv
// rtl/digest_streamer.sv - serialises one captured SHA digest onto an AXI4-Stream master
module digest_streamer
  import sha_pkg::*;
#(
  parameter int P_M_AXIS_DATA_WIDTH = 64,
  parameter int DIGEST_WIDTH        = 512
) (
  input  logic                             axi_aclk,
  input  logic                             reset,
  input  logic [DIGEST_WIDTH-1:0]          s_digest,
  input  logic [1:0]                       s_digest_type,
  input  logic                             s_digest_valid,
  output logic                             s_digest_ready,
  output logic [P_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [P_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast
);

  localparam int NB = P_M_AXIS_DATA_WIDTH / 8;
  localparam int LG = $clog2(NB);
  localparam int CW = $clog2(512 / NB) + 1;
  localparam logic [6:0] NB7 = 7'(NB);

  state_t                  state;
  logic [DIGEST_WIDTH-1:0] shreg;
  logic [CW-1:0]           beat_cnt;
  logic [6:0]              bytes_left;
  logic                    ready_q;
  logic                    tvalid_q;

  logic [6:0] cap_len;
  logic [6:0] cap_beats;

  assign cap_len   = digest_len(s_digest_type);
  assign cap_beats = (cap_len + 7'(NB - 1)) >> LG;

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ready_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      shreg      <= '0;
      beat_cnt   <= '0;
      bytes_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (s_digest_valid && ready_q) begin
            shreg      <= s_digest;
            beat_cnt   <= CW'(cap_beats - 7'd1);
            bytes_left <= cap_len;
            ready_q    <= 1'b0;
            tvalid_q   <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (m_axis_tready) begin
            if (beat_cnt == '0) begin
              tvalid_q <= 1'b0;
              ready_q  <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              shreg      <= shreg << P_M_AXIS_DATA_WIDTH;
              beat_cnt   <= beat_cnt - CW'(1);
              bytes_left <= bytes_left - NB7;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Lane j carries the j-th most significant byte still held in the shift register.
  always_comb begin
    m_axis_tkeep = '0;
    m_axis_tdata = '0;
    for (int j = 0; j < NB; j++) begin
      if (tvalid_q && (bytes_left > 7'(j))) begin
        m_axis_tkeep[j]       = 1'b1;
        m_axis_tdata[8*j +: 8] = shreg[DIGEST_WIDTH-1-8*j -: 8];
      end
    end
  end

  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tvalid_q && (beat_cnt == '0);
  assign s_digest_ready = ready_q;

endmodule

// File: tb/tb_digest_streamer.sv
// tb/tb_digest_streamer.sv - scoreboard bench for digest_streamer at 64/256/512-bit widths
module tb_digest_streamer;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] dig  [3];
  logic [1:0]   typ  [3];
  logic         vld  [3];
  logic         rdy  [3];
  logic         trdy [3];
  logic         tv   [3];
  logic         tl   [3];
  logic [511:0] od   [3];
  logic [63:0]  okp  [3];

  logic [63:0]  td0;
  logic [7:0]   tk0;
  logic [255:0] td1;
  logic [31:0]  tk1;
  logic [511:0] td2;
  logic [63:0]  tk2;

  beat_t expq [3][$];
  int    hs_cnt [3];
  int    last_hs_cyc [3];
  int    cap_cyc [3];
  bit    held [3];
  beat_t hold_v [3];
  int    cyc;
  int    vectors;
  int    miscompares;

  always #5 clk = ~clk;

  digest_streamer #(.P_M_AXIS_DATA_WIDTH(64)) dut0 (
    .axi_aclk(clk), .reset(rst), .s_digest(dig[0]), .s_digest_type(typ[0]),
    .s_digest_valid(vld[0]), .s_digest_ready(rdy[0]), .m_axis_tdata(td0),
    .m_axis_tkeep(tk0), .m_axis_tvalid(tv[0]), .m_axis_tready(trdy[0]), .m_axis_tlast(tl[0]));

  digest_streamer #(.P_M_AXIS_DATA_WIDTH(256)) dut1 (
    .axi_aclk(clk), .reset(rst), .s_digest(dig[1]), .s_digest_type(typ[1]),
    .s_digest_valid(vld[1]), .s_digest_ready(rdy[1]), .m_axis_tdata(td1),
    .m_axis_tkeep(tk1), .m_axis_tvalid(tv[1]), .m_axis_tready(trdy[1]), .m_axis_tlast(tl[1]));

  digest_streamer #(.P_M_AXIS_DATA_WIDTH(512)) dut2 (
    .axi_aclk(clk), .reset(rst), .s_digest(dig[2]), .s_digest_type(typ[2]),
    .s_digest_valid(vld[2]), .s_digest_ready(rdy[2]), .m_axis_tdata(td2),
    .m_axis_tkeep(tk2), .m_axis_tvalid(tv[2]), .m_axis_tready(trdy[2]), .m_axis_tlast(tl[2]));

  assign od[0]  = {448'b0, td0};
  assign od[1]  = {256'b0, td1};
  assign od[2]  = td2;
  assign okp[0] = {56'b0, tk0};
  assign okp[1] = {32'b0, tk1};
  assign okp[2] = tk2;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: compares every handshaken beat against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst && tv[i]) begin
        if (held[i]) begin
          check("stall_tdata", od[i], hold_v[i].data);
          check("stall_tkeep", {448'b0, okp[i]}, {448'b0, hold_v[i].keep});
          check("stall_tlast", {511'b0, tl[i]}, {511'b0, hold_v[i].last});
        end
        check("ready_low_in_send", {511'b0, rdy[i]}, 512'd0);
        if (trdy[i]) begin
          if (expq[i].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat inst%0d: got %0h expected none", i, od[i]);
          end else begin
            beat_t e;
            e = expq[i].pop_front();
            check("tdata", od[i], e.data);
            check("tkeep", {448'b0, okp[i]}, {448'b0, e.keep});
            check("tlast", {511'b0, tl[i]}, {511'b0, e.last});
          end
          hs_cnt[i]++;
          if (tl[i]) last_hs_cyc[i] = cyc;
        end
        held[i]   = !trdy[i];
        hold_v[i] = '{od[i], okp[i], tl[i]};
      end else begin
        held[i] = 1'b0;
      end
      if (!rst && vld[i] && rdy[i]) cap_cyc[i] = cyc;
    end
  end

  function automatic logic [511:0] mk(input int start, input int dlen);
    logic [511:0] d;
    for (int n = 0; n < 64; n++)
      d[511-8*n -: 8] = (n < dlen) ? 8'(start + n) : 8'hEE;
    return d;
  endfunction

  task automatic push_model(input int i, input logic [511:0] d, input logic [1:0] t);
    int nb, dlen, beats;
    nb    = (i == 0) ? 8 : (i == 1) ? 32 : 64;
    dlen  = (t == 2'b00) ? 32 : (t == 2'b01) ? 48 : 64;
    beats = (dlen + nb - 1) / nb;
    for (int k = 0; k < beats; k++) begin
      beat_t b;
      b = '0;
      for (int j = 0; j < nb; j++) begin
        if (k * nb + j < dlen) begin
          b.keep[j]       = 1'b1;
          b.data[8*j +: 8] = d[511-8*(k*nb+j) -: 8];
        end
      end
      b.last = (k == beats - 1);
      expq[i].push_back(b);
    end
  endtask

  task automatic send(input int i, input logic [511:0] d, input logic [1:0] t, input bit hold);
    int n;
    dig[i] = d;
    typ[i] = t;
    vld[i] = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rdy[i]) break;
    end
    if (n == 200) begin
      vectors++;
      miscompares++;
      $display("FAIL capture_timeout inst%0d: got ready=0 expected ready=1", i);
    end
    @(posedge clk);
    #1;
    if (!hold) vld[i] = 1'b0;
  endtask

  task automatic wait_hs(input int i, input int target);
    int n;
    for (n = 0; n < 300; n++) begin
      if (hs_cnt[i] >= target) break;
      @(posedge clk);
      #1;
    end
    if (n == 300) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout inst%0d: got %0d expected %0d", i, hs_cnt[i], target);
    end
  endtask

  task automatic wait_empty(input int i);
    int n;
    for (n = 0; n < 500; n++) begin
      if (expq[i].size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (n == 500) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout inst%0d: got %0d pending expected 0", i, expq[i].size());
    end
  endtask

  initial begin
    int base;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst         = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dig[i] = '0; typ[i] = 2'b00; vld[i] = 1'b0; trdy[i] = 1'b1;
      hs_cnt[i] = 0; last_hs_cyc[i] = 0; cap_cyc[i] = 0; held[i] = 1'b0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_tvalid", {511'b0, tv[i]}, 512'd0);
      check("rst_tlast", {511'b0, tl[i]}, 512'd0);
      check("rst_tkeep", {448'b0, okp[i]}, 512'd0);
      check("rst_tdata", od[i], 512'd0);
      check("rst_ready", {511'b0, rdy[i]}, 512'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check("idle_ready", {511'b0, rdy[i]}, 512'd1);
    @(posedge clk);
    #1;

    // SHA256 on 64-bit lanes, hand-computed beats.
    expq[0].push_back('{512'h0706050403020100, 64'hFF, 1'b0});
    expq[0].push_back('{512'h0F0E0D0C0B0A0908, 64'hFF, 1'b0});
    expq[0].push_back('{512'h1716151413121110, 64'hFF, 1'b0});
    expq[0].push_back('{512'h1F1E1D1C1B1A1918, 64'hFF, 1'b1});
    send(0, mk(0, 32), 2'b00, 1'b0);
    wait_empty(0);

    // SHA384 on 256-bit lanes: second beat is half full.
    push_model(1, mk(0, 48), 2'b01);
    send(1, mk(0, 48), 2'b01, 1'b0);
    wait_empty(1);

    // SHA512 on 64-bit lanes with a 3-cycle stall on beat 2; type change after capture ignored.
    base = hs_cnt[0];
    push_model(0, mk(8'h40, 64), 2'b10);
    send(0, mk(8'h40, 64), 2'b10, 1'b0);
    typ[0] = 2'b00;
    wait_hs(0, base + 2);
    trdy[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    trdy[0] = 1'b1;
    wait_empty(0);

    // Back-to-back digests with valid held high.
    push_model(0, mk(8'h10, 32), 2'b00);
    push_model(0, mk(8'h60, 48), 2'b01);
    send(0, mk(8'h10, 32), 2'b00, 1'b1);
    send(0, mk(8'h60, 48), 2'b01, 1'b0);
    check("b2b_gap", 512'(cap_cyc[0] - last_hs_cyc[0]), 512'd1);
    wait_empty(0);

    // Reset after beat 1 of a SHA512 digest, then a clean SHA256.
    base = hs_cnt[0];
    push_model(0, mk(8'hA0, 64), 2'b10);
    send(0, mk(8'hA0, 64), 2'b10, 1'b0);
    wait_hs(0, base + 2);
    rst     = 1'b1;
    trdy[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_tvalid", {511'b0, tv[0]}, 512'd0);
    check("midrst_ready", {511'b0, rdy[0]}, 512'd0);
    expq[0].delete();
    @(negedge clk);
    check("postrst_ready", {511'b0, rdy[0]}, 512'd1);
    @(posedge clk);
    #1;
    trdy[0] = 1'b1;
    push_model(0, mk(8'hC0, 32), 2'b00);
    send(0, mk(8'hC0, 32), 2'b00, 1'b0);
    wait_empty(0);

    // Type 2'b11 on 512-bit lanes behaves as SHA512: one full beat.
    push_model(2, mk(8'h30, 64), 2'b10);
    send(2, mk(8'h30, 64), 2'b11, 1'b0);
    wait_empty(2);

    repeat (4) @(posedge clk);
    for (int i = 0; i < 3; i++) check("queue_empty", 512'(expq[i].size()), 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
